// File: rtl/gb_lcd_pixel_tx_if.sv
// Tile-row conduit between the PPU fetcher (master) and the pixel transmitter (slave).
interface gb_lcd_pixel_tx_if;
   logic [7:0] row_lo;
   logic [7:0] row_hi;
   logic       row_valid;
   logic       row_ready;

   modport master (output row_lo, output row_hi, output row_valid, input row_ready);
   modport slave  (input row_lo, input row_hi, input row_valid, output row_ready);
endinterface

// File: rtl/gb_lcd_pixel_tx.sv
// GameBoy LCD pixel transmitter: DMG dot/line timing, 16-entry pixel FIFO fed by
// 2bpp tile rows, BGP palette mapping and a fixed 160 pixels per visible line.
module gb_lcd_pixel_tx #(
   parameter int unsigned DOTS_PER_LINE   = 456,
   parameter int unsigned LINES_PER_FRAME = 154,
   parameter int unsigned VISIBLE_LINES   = 144,
   parameter int unsigned LINE_PIXELS     = 160,
   parameter int unsigned DRAW_START      = 80
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     lcd_en,
   input  logic [7:0]               bgp,
   gb_lcd_pixel_tx_if.slave         row_if,
   input  logic                     underrun_clr,
   output logic [1:0]               LD,
   output logic                     PX_VALID,
   output logic [7:0]               LX,
   output logic [7:0]               LY,
   output logic [1:0]               MODE,
   output logic                     frame_start,
   output logic                     vblank_start,
   output logic                     underrun
);

   localparam int unsigned DrawEnd   = DRAW_START + LINE_PIXELS;
   localparam int unsigned FifoDepth = 16;

   typedef enum logic [1:0] {
      ModeHblank = 2'd0,
      ModeVblank = 2'd1,
      ModeOam    = 2'd2,
      ModeDraw   = 2'd3
   } mode_e;

   logic [8:0] dot_q, dot_d;
   logic [7:0] ly_q, ly_d;
   logic [4:0] count_q, count_d;
   logic [4:0] base;
   logic [1:0] fifo_q [FifoDepth];
   logic [1:0] fifo_d [FifoDepth];
   logic [1:0] ld_q;
   logic       px_valid_q;
   logic [7:0] lx_q;
   mode_e      mode_q, mode_d;
   logic       frame_start_q, vblank_start_q, underrun_q;

   logic       last_dot, pop_slot, push, fifo_empty, ready;
   logic [1:0] colour, shade;

   // Slot decode, handshake and palette lookup for the pixel leaving this cycle
   always_comb begin
      last_dot   = (dot_q == 9'(DOTS_PER_LINE - 1));
      pop_slot   = (ly_q < 8'(VISIBLE_LINES)) && (dot_q >= 9'(DRAW_START))
                   && (dot_q < 9'(DrawEnd));
      ready      = reset_n && lcd_en && (count_q <= 5'd8) && !last_dot;
      push       = row_if.row_valid && ready;
      fifo_empty = (count_q == 5'd0);
      // An empty FIFO still emits a pixel (colour 0) so the frame count never slips
      colour     = fifo_empty ? 2'b00 : fifo_q[0];
      shade      = bgp[{colour, 1'b0} +: 2];
   end

   assign row_if.row_ready = ready;

   // Dot/line counters and the mode the next cycle will report
   always_comb begin
      dot_d = last_dot ? 9'd0 : dot_q + 9'd1;
      ly_d  = ly_q;
      if (last_dot) begin
         ly_d = (ly_q == 8'(LINES_PER_FRAME - 1)) ? 8'd0 : ly_q + 8'd1;
      end
      if (ly_q >= 8'(VISIBLE_LINES)) begin
         mode_d = ModeVblank;
      end else if (dot_q < 9'(DRAW_START)) begin
         mode_d = ModeOam;
      end else if (dot_q < 9'(DrawEnd)) begin
         mode_d = ModeDraw;
      end else begin
         mode_d = ModeHblank;
      end
   end

   // FIFO next state: pop the head first, then append the new row behind what remains
   always_comb begin
      fifo_d  = fifo_q;
      base    = count_q;
      if (pop_slot && !fifo_empty) begin
         for (int i = 0; i < FifoDepth - 1; i++) begin
            fifo_d[i] = fifo_q[i + 1];
         end
         fifo_d[FifoDepth - 1] = 2'b00;
         base = count_q - 5'd1;
      end
      // base <= 8 whenever push is allowed, so base+7 stays inside the array
      if (push) begin
         for (int i = 0; i < 8; i++) begin
            fifo_d[base[3:0] + 4'(i)] = {row_if.row_hi[3'(7 - i)], row_if.row_lo[3'(7 - i)]};
         end
      end
      count_d = push ? base + 5'd8 : base;
      // Leftover pixels never carry into the next line
      if (last_dot) begin
         count_d = 5'd0;
      end
   end

   // FIFO storage; occupancy is tracked separately so the payload needs no reset
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   // Timing, emission and flag registers; lcd_en low idles everything but underrun
   always_ff @(posedge clk) begin
      if (!reset_n || !lcd_en) begin
         dot_q          <= 9'd0;
         ly_q           <= 8'd0;
         count_q        <= 5'd0;
         ld_q           <= 2'b00;
         px_valid_q     <= 1'b0;
         lx_q           <= 8'd0;
         mode_q         <= ModeHblank;
         frame_start_q  <= 1'b0;
         vblank_start_q <= 1'b0;
         underrun_q     <= reset_n ? underrun_q : 1'b0;
      end else begin
         dot_q          <= dot_d;
         ly_q           <= ly_d;
         count_q        <= count_d;
         px_valid_q     <= pop_slot;
         ld_q           <= pop_slot ? shade : 2'b00;
         lx_q           <= pop_slot ? 8'(dot_q - 9'(DRAW_START)) : 8'd0;
         mode_q         <= mode_d;
         frame_start_q  <= (dot_q == 9'd0) && (ly_q == 8'd0);
         vblank_start_q <= (dot_q == 9'd0) && (ly_q == 8'(VISIBLE_LINES));
         // A new underrun beats a simultaneous clear
         if (pop_slot && fifo_empty) begin
            underrun_q <= 1'b1;
         end else if (underrun_clr) begin
            underrun_q <= 1'b0;
         end
      end
   end

   assign LD           = ld_q;
   assign PX_VALID     = px_valid_q;
   assign LX           = lx_q;
   assign LY           = ly_q;
   assign MODE         = mode_q;
   assign frame_start  = frame_start_q;
   assign vblank_start = vblank_start_q;
   assign underrun     = underrun_q;

endmodule
